// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle main control sequencer.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXECUTE,
    S_ALU_WB,
    S_BRANCH,
    S_JUMP,
    S_ERROR
  } state_e;

  // States that wait on the memory handshake and are guarded by the timeout.
  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath/memory (slave).
interface mc_sequencer_if #(parameter int CNT_W = 32);

  logic [5:0]       op_code;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic             mem_timeout;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  op_code, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_timeout, instr_retired
  );

  modport slave (
    output op_code, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_timeout, instr_retired
  );

endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready within one memory access.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] count_q;

  // The wait that brings the count up to MEM_TIMEOUT is the expiring one.
  assign expired_o = tick_i && (count_q == LAST);

  // Clear has priority so every new access starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (tick_i) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute over a shared ALU and memory.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mc_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             timeout_q;
  logic             retire;
  logic             set_illegal;
  logic             set_timeout;
  logic             wait_tick;
  logic             expired;

  assign wait_tick = is_mem_state(state_q) && !bus.mem_ready;

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_d != state_q),
    .tick_i    (wait_tick),
    .expired_o (expired)
  );

  assign bus.illegal_op    = illegal_q;
  assign bus.mem_timeout   = timeout_q;
  assign bus.instr_retired = retired_q;

  // State register, opcode latch, retire counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.op_code;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  // Next-state and per-state datapath controls; only the FETCH handshake outputs are Mealy.
  always_comb begin
    state_d           = state_q;
    retire            = 1'b0;
    set_illegal       = 1'b0;
    set_timeout       = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = ALUSRCB_B;
    bus.alu_op        = ALU_OP_ADD;
    bus.pc_source     = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = ALUSRCB_FOUR;
        if (bus.mem_ready) begin
          bus.ir_write  = 1'b1;
          bus.pc_write  = 1'b1;
          bus.pc_source = PCSRC_ALU;
          state_d       = S_DECODE;
        end else if (expired) begin
          set_timeout = 1'b1;
          state_d     = S_ERROR;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = ALUSRCB_IMM_SH;
        case (bus.op_code)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            set_illegal = 1'b1;
            state_d     = S_ERROR;
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALUSRCB_IMM;
        state_d       = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (expired) begin
          set_timeout = 1'b1;
          state_d     = S_ERROR;
        end
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = S_FETCH;
        retire         = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (expired) begin
          set_timeout = 1'b1;
          state_d     = S_ERROR;
        end
      end
      S_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_OP_FUNCT;
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_OP_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
        state_d           = S_FETCH;
        retire            = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCSRC_JUMP;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer, built with MEM_TIMEOUT=4 and CNT_W=4.
module tb_mc_sequencer;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEM_ADDR = 2, ST_MEM_READ = 3,
                 ST_MEM_WB = 4, ST_MEM_WRITE = 5, ST_EXECUTE = 6, ST_ALU_WB = 7,
                 ST_BRANCH = 8, ST_JUMP = 9, ST_ERROR = 10;

  localparam logic [5:0] OPC_R = 6'b000000, OPC_LW = 6'b100011, OPC_SW = 6'b101011,
                         OPC_BEQ = 6'b000100, OPC_J = 6'b000010, OPC_BAD = 6'b111111;

  typedef struct {
    logic        rdy;
    logic [15:0] vec;
    int          st;
  } item_t;

  logic clk;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;
  item_t sb[$];

  mc_sequencer_if #(.CNT_W(4)) bus ();

  mc_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] observed();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source};
  endfunction

  // Reference control table, one entry per state.
  function automatic logic [15:0] out_vec(int st, logic rdy);
    logic pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      ST_FETCH:     begin mr = 1; asb = 2'b01; if (rdy) begin irw = 1; pcw = 1; end end
      ST_DECODE:    asb = 2'b11;
      ST_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
      ST_MEM_READ:  begin mr = 1; iord = 1; end
      ST_MEM_WB:    begin rw = 1; m2r = 1; end
      ST_MEM_WRITE: begin mw = 1; iord = 1; end
      ST_EXECUTE:   begin asa = 1; aop = 2'b10; end
      ST_ALU_WB:    begin rw = 1; rdst = 1; end
      ST_BRANCH:    begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      ST_JUMP:      begin pcw = 1; psrc = 2'b10; end
      default:      ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, asa, asb, aop, psrc};
  endfunction

  task automatic push(int st, logic rdy);
    item_t it;
    it.st = st; it.rdy = rdy; it.vec = out_vec(st, rdy);
    sb.push_back(it);
  endtask

  // Queue the expected state walk of one instruction with memory always ready.
  task automatic push_instr(logic [5:0] op);
    push(ST_FETCH, 1'b1);
    push(ST_DECODE, 1'b1);
    case (op)
      OPC_R:   begin push(ST_EXECUTE, 1'b1); push(ST_ALU_WB, 1'b1); end
      OPC_LW:  begin push(ST_MEM_ADDR, 1'b1); push(ST_MEM_READ, 1'b1); push(ST_MEM_WB, 1'b1); end
      OPC_SW:  begin push(ST_MEM_ADDR, 1'b1); push(ST_MEM_WRITE, 1'b1); end
      OPC_BEQ: push(ST_BRANCH, 1'b1);
      OPC_J:   push(ST_JUMP, 1'b1);
      default: ;
    endcase
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    apply_reset();
    @(negedge clk);
    obs = observed();
    total++;
    if (obs !== out_vec(ST_FETCH, 1'b0))
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs, out_vec(ST_FETCH, 1'b0));
    else passed++;
    total++;
    if ({bus.instr_retired, bus.illegal_op, bus.mem_timeout} !== 6'b0)
      $display("[TB] FAIL reset_status: got %h expected 00",
               {bus.instr_retired, bus.illegal_op, bus.mem_timeout});
    else passed++;
    next_cycle();
  endtask

  task automatic test_sequence();
    logic [5:0] prog [5] = '{OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_J};
    int cycles = 0;
    for (int i = 0; i < 5; i++) begin
      bus.op_code = prog[i];
      push_instr(prog[i]);
      while (sb.size() > 0) begin
        item_t it = sb.pop_front();
        logic [15:0] obs;
        bus.mem_ready = it.rdy;
        @(negedge clk);
        obs = observed();
        total++;
        if (obs !== it.vec)
          $display("[TB] FAIL seq_instr%0d_state%0d: got %h expected %h", i, it.st, obs, it.vec);
        else passed++;
        cycles++;
        next_cycle();
      end
      total++;
      if (bus.instr_retired !== 4'(i + 1))
        $display("[TB] FAIL seq_retired%0d: got %0d expected %0d", i, bus.instr_retired, i + 1);
      else passed++;
    end
    total++;
    if (cycles != 19) $display("[TB] FAIL seq_cycles: got %0d expected 19", cycles);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [15:0] obs;
    bus.op_code = OPC_LW;
    push(ST_FETCH, 1'b1); push(ST_DECODE, 1'b1); push(ST_MEM_ADDR, 1'b1);
    push(ST_MEM_READ, 1'b0);
    while (sb.size() > 0) begin
      item_t it = sb.pop_front();
      bus.mem_ready = it.rdy;
      @(negedge clk);
      obs = observed();
      total++;
      if (obs !== it.vec)
        $display("[TB] FAIL arst_state%0d: got %h expected %h", it.st, obs, it.vec);
      else passed++;
      next_cycle();
    end
    #2 rst_n = 1'b0;
    #1;
    obs = observed();
    total++;
    if (obs !== out_vec(ST_FETCH, 1'b0))
      $display("[TB] FAIL arst_outputs: got %h expected %h", obs, out_vec(ST_FETCH, 1'b0));
    else passed++;
    total++;
    if (bus.instr_retired !== 4'd0)
      $display("[TB] FAIL arst_retired: got %0d expected 0", bus.instr_retired);
    else passed++;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_lw_wait();
    int mr_cycles = 0;
    bus.op_code = OPC_LW;
    push(ST_FETCH, 1'b1); push(ST_DECODE, 1'b1); push(ST_MEM_ADDR, 1'b1);
    for (int k = 0; k < 3; k++) push(ST_MEM_READ, 1'b0);
    push(ST_MEM_READ, 1'b1); push(ST_MEM_WB, 1'b0);
    while (sb.size() > 0) begin
      item_t it = sb.pop_front();
      logic [15:0] obs;
      bus.mem_ready = it.rdy;
      @(negedge clk);
      obs = observed();
      if (it.st == ST_MEM_READ && bus.mem_read === 1'b1) mr_cycles++;
      total++;
      if (obs !== it.vec)
        $display("[TB] FAIL lw_wait_state%0d: got %h expected %h", it.st, obs, it.vec);
      else passed++;
      next_cycle();
    end
    total++;
    if (mr_cycles != 4) $display("[TB] FAIL lw_wait_read_cycles: got %0d expected 4", mr_cycles);
    else passed++;
    total++;
    if (bus.instr_retired !== 4'd1)
      $display("[TB] FAIL lw_wait_retired: got %0d expected 1", bus.instr_retired);
    else passed++;
  endtask

  task automatic test_illegal();
    bus.op_code = OPC_BAD;
    push(ST_FETCH, 1'b1); push(ST_DECODE, 1'b1);
    for (int k = 0; k < 20; k++) push(ST_ERROR, 1'b1);
    while (sb.size() > 0) begin
      item_t it = sb.pop_front();
      logic [15:0] obs;
      bus.mem_ready = it.rdy;
      @(negedge clk);
      obs = observed();
      total++;
      if (obs !== it.vec)
        $display("[TB] FAIL illegal_state%0d: got %h expected %h", it.st, obs, it.vec);
      else passed++;
      next_cycle();
    end
    total++;
    if (bus.illegal_op !== 1'b1) $display("[TB] FAIL illegal_flag: got %b expected 1", bus.illegal_op);
    else passed++;
    total++;
    if (bus.instr_retired !== 4'd1)
      $display("[TB] FAIL illegal_retired_frozen: got %0d expected 1", bus.instr_retired);
    else passed++;
  endtask

  task automatic test_timeout();
    logic irw_seen = 1'b0;
    apply_reset();
    for (int k = 0; k < 4; k++) push(ST_FETCH, 1'b0);
    for (int k = 0; k < 3; k++) push(ST_ERROR, 1'b0);
    while (sb.size() > 0) begin
      item_t it = sb.pop_front();
      logic [15:0] obs;
      bus.mem_ready = it.rdy;
      @(negedge clk);
      obs = observed();
      irw_seen |= bus.ir_write;
      total++;
      if (obs !== it.vec)
        $display("[TB] FAIL timeout_state%0d: got %h expected %h", it.st, obs, it.vec);
      else passed++;
      next_cycle();
    end
    total++;
    if (bus.mem_timeout !== 1'b1) $display("[TB] FAIL timeout_flag: got %b expected 1", bus.mem_timeout);
    else passed++;
    total++;
    if (irw_seen !== 1'b0) $display("[TB] FAIL timeout_ir_write: got %b expected 0", irw_seen);
    else passed++;
  endtask

  task automatic test_wrap();
    apply_reset();
    bus.op_code = OPC_J;
    for (int n = 1; n <= 17; n++) begin
      push_instr(OPC_J);
      while (sb.size() > 0) begin
        item_t it = sb.pop_front();
        logic [15:0] obs;
        bus.mem_ready = it.rdy;
        @(negedge clk);
        obs = observed();
        total++;
        if (obs !== it.vec)
          $display("[TB] FAIL wrap_j%0d_state%0d: got %h expected %h", n, it.st, obs, it.vec);
        else passed++;
        next_cycle();
      end
      if (n == 16) begin
        total++;
        if (bus.instr_retired !== 4'd0)
          $display("[TB] FAIL wrap_at16: got %0d expected 0", bus.instr_retired);
        else passed++;
      end
    end
    total++;
    if (bus.instr_retired !== 4'd1)
      $display("[TB] FAIL wrap_at17: got %0d expected 1", bus.instr_retired);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.op_code = OPC_R;
    #12;
    test_reset();
    test_sequence();
    test_async_reset();
    test_lw_wait();
    test_illegal();
    test_timeout();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
